// File: rtl/ysyx_25040111_icache_sa.sv
// Set-associative read-only instruction cache between IFU and the memory bridge.
// Misses refill a whole block with one burst; replacement is per-set round-robin.
module ysyx_25040111_icache_sa #(
    parameter int WAYS_Ls  = 1,
    parameter int SETS_Ls  = 3,
    parameter int BLOCK_Ls = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] addr,
    output logic        ready,
    output logic [31:0] data,
    input  logic        flush,
    output logic        rstart,
    output logic [31:0] raddr,
    output logic [7:0]  rlen,
    input  logic        rok,
    input  logic [31:0] rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int WAYS  = 1 << WAYS_Ls;
    localparam int SETS  = 1 << SETS_Ls;
    localparam int WORDS = 1 << (BLOCK_Ls - 2);
    localparam int WAY_W = (WAYS_Ls > 0) ? WAYS_Ls : 1;
    localparam int IDX_W = (SETS_Ls > 0) ? SETS_Ls : 1;
    localparam int WRD_W = (BLOCK_Ls > 2) ? BLOCK_Ls - 2 : 1;
    localparam int TAG_W = 32 - BLOCK_Ls - SETS_Ls;
    localparam logic [31:0] BLK_MASK = ~(32'((1 << BLOCK_Ls) - 1));

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        idx_of = IDX_W'((a >> BLOCK_Ls) & 32'(SETS - 1));
    endfunction

    function automatic logic [WRD_W-1:0] word_of(input logic [31:0] a);
        word_of = WRD_W'((a >> 2) & 32'(WORDS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        tag_of = TAG_W'(a >> (BLOCK_Ls + SETS_Ls));
    endfunction

    logic [1:0]       state_q;
    logic [31:0]      req_addr_q;
    logic [WAY_W-1:0] victim_q;
    logic [WRD_W-1:0] beat_q;
    logic             flush_pend_q;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] ptr_q   [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      mem_q   [SETS][WAYS][WORDS];

    logic [IDX_W-1:0] lk_idx, rf_idx;
    logic [WRD_W-1:0] lk_word, rf_word;
    logic [TAG_W-1:0] lk_tag, rf_tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way, vict;
    logic             found;

    assign rlen    = 8'(WORDS - 1);
    assign lk_idx  = idx_of(addr);
    assign lk_word = word_of(addr);
    assign lk_tag  = tag_of(addr);
    assign rf_idx  = idx_of(req_addr_q);
    assign rf_word = word_of(req_addr_q);
    assign rf_tag  = tag_of(req_addr_q);

    // Lookup: hit way, and victim = lowest invalid way else the set pointer.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vict    = ptr_q[lk_idx];
        found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found && !valid_q[lk_idx][w]) begin
                vict  = WAY_W'(w);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ready        <= 1'b0;
            data         <= '0;
            rstart       <= 1'b0;
            raddr        <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            flush_pend_q <= 1'b0;
            req_addr_q   <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            ready  <= 1'b0;
            rstart <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A flush beats a same-cycle request; ready gates the held valid.
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            ptr_q[s]   <= '0;
                        end
                    end else if (valid && !ready) begin
                        req_addr_q <= addr;
                        if (hit) begin
                            ready   <= 1'b1;
                            data    <= mem_q[lk_idx][hit_way][lk_word];
                            hit_cnt <= hit_cnt + 32'd1;
                        end else begin
                            rstart   <= 1'b1;
                            raddr    <= addr & BLK_MASK;
                            miss_cnt <= miss_cnt + 32'd1;
                            victim_q <= vict;
                            beat_q   <= '0;
                            state_q  <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (rok) begin
                        beat_q <= beat_q + WRD_W'(1);
                        if (beat_q == WRD_W'(WORDS - 1)) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready <= 1'b1;
                    data  <= mem_q[rf_idx][victim_q][rf_word];
                    if (flush_pend_q || flush) begin
                        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                    end else begin
                        valid_q[rf_idx][victim_q] <= 1'b1;
                    end
                    if (WAYS > 1 && victim_q == ptr_q[rf_idx])
                        ptr_q[rf_idx] <= victim_q + WAY_W'(1);
                    flush_pend_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Block data and tags carry no reset; valid bits decide whether they are used.
    always_ff @(posedge clock) begin
        if (!reset && state_q == S_REFILL && rok)
            mem_q[rf_idx][victim_q][beat_q] <= rdata;
        if (!reset && state_q == S_DONE)
            tag_q[rf_idx][victim_q] <= rf_tag;
    end

endmodule
